usb_protocol_controller: RTL and testbench

Transaction-level controller for the USB device endpoint. It consumes decoded packet events from the RX packet decoder and sequences OUT/IN transactions. It arbitrates ownership of the shared data buffer between the USB side and the AHB side, and commands the TX packet encoder to send DATA, ACK or NAK.

---
 rtl/usb_pkg.sv | 51 +++++
 rtl/usb_protocol_controller_timeout_counter.sv | 42 ++++
 rtl/usb_protocol_controller.sv | 233 +++++++++++++++++++++++
 tb/tb_usb_protocol_controller.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usb_pkg
// Description : Shared types for the USB device endpoint protocol controller:
//               decoded RX PIDs, TX encoder commands and controller states.
// Revision    : 1.0 - initial release
// ============================================================================
package usb_pkg;

    // PID codes delivered by the RX packet decoder (code 6 is unused)
    typedef enum logic [2:0] {
        RX_NONE = 3'd0,
        RX_OUT  = 3'd1,
        RX_IN   = 3'd2,
        RX_DATA = 3'd3,
        RX_ACK  = 3'd4,
        RX_NAK  = 3'd5,
        RX_ERR  = 3'd7
    } rx_pid_t;

    // Packet types the TX packet encoder can be told to send
    typedef enum logic [1:0] {
        TX_NONE = 2'd0,
        TX_DATA = 2'd1,
        TX_ACK  = 2'd2,
        TX_NAK  = 2'd3
    } tx_pid_t;

    // Transaction sequencer states
    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        RX_WAIT_DATA = 3'd1,
        RX_RECEIVING = 3'd2,
        SEND_ACK     = 3'd3,
        SEND_NAK     = 3'd4,
        TX_SEND_DATA = 3'd5,
        TX_WAIT_ACK  = 3'd6
    } ctrl_state_t;

    // True for the states that drive a packet out through the TX encoder
    function automatic logic is_tx_state(input ctrl_state_t s);
        return (s == SEND_ACK) || (s == SEND_NAK) || (s == TX_SEND_DATA);
    endfunction

    // True for the states that wait on the host and therefore can time out
    function automatic logic is_wait_state(input ctrl_state_t s);
        return (s == RX_WAIT_DATA) || (s == TX_WAIT_ACK);
    endfunction

endpackage
`default_nettype wire

// File: rtl/usb_protocol_controller_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module      : timeout_counter
// Description : Free-running wait counter. Counts while enabled and flags a
//               one-cycle timeout when the count reaches the rollover value.
// Revision    : 1.0 - initial release
// ============================================================================
module timeout_counter #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             count_enable,
    input  logic [WIDTH-1:0] rollover_val,
    output logic             timeout
);

    logic [WIDTH-1:0] r_count;
    logic             w_at_roll;

    assign w_at_roll = (r_count == rollover_val);

    // Count cycles while enabled; clear has priority and wraps at rollover
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (count_enable) begin
            if (w_at_roll) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign timeout = count_enable && w_at_roll;

endmodule
`default_nettype wire

// File: rtl/usb_protocol_controller.sv
`default_nettype none
// ============================================================================
// Module      : usb_protocol_controller
// Description : Sequences USB OUT/IN transactions from decoded RX packet
//               events, arbitrates the shared data buffer between the USB and
//               AHB sides, and commands DATA/ACK/NAK packets on the TX side.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_protocol_controller
    import usb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 640,
    parameter int ADDR_W         = 7
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              rx_packet_valid,
    input  logic [2:0]        rx_packet,
    input  logic              rx_done,
    input  logic              rx_crc_ok,
    input  logic              tx_done,
    input  logic              tx_ready,
    input  logic [ADDR_W-1:0] buffer_occupancy,
    output logic              tx_start,
    output logic [1:0]        tx_packet,
    output logic              d_mode,
    output logic              clear_buffer,
    output logic              rx_data_ready,
    output logic              rx_transfer_active,
    output logic              tx_transfer_active,
    output logic              error
);

    // Counter just wide enough to hold TIMEOUT_CYCLES-1
    localparam int c_cnt_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_rollover = c_cnt_w'(TIMEOUT_CYCLES - 1);

    ctrl_state_t r_state;
    ctrl_state_t w_next_state;

    logic    w_set_error;
    logic    w_clr_error;
    logic    w_clear_req;
    logic    w_set_rdr;
    logic    w_occ_zero;
    logic    w_cnt_en;
    logic    w_timeout;
    logic    w_tx_start_next;
    tx_pid_t w_tx_pid;

    logic    r_tx_start;
    logic    r_clear;
    logic    r_error;
    logic    r_rdr;

    assign w_occ_zero = (buffer_occupancy == '0);

    // Counter is held at zero outside the waiting states, so it starts from
    // zero on every entry into RX_WAIT_DATA or TX_WAIT_ACK.
    assign w_cnt_en = is_wait_state(r_state);

    timeout_counter #(
        .WIDTH (c_cnt_w)
    ) u_timeout (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (!w_cnt_en),
        .count_enable (w_cnt_en),
        .rollover_val (c_rollover),
        .timeout      (w_timeout)
    );

    // State register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and the one-cycle requests that update the flag registers
    always_comb begin
        w_next_state = r_state;
        w_set_error  = 1'b0;
        w_clr_error  = 1'b0;
        w_clear_req  = 1'b0;
        w_set_rdr    = 1'b0;
        case (r_state)
            IDLE: begin
                if (rx_packet_valid) begin
                    case (rx_packet)
                        RX_OUT: begin
                            if (w_occ_zero) begin
                                w_next_state = RX_WAIT_DATA;
                                w_clr_error  = 1'b1;
                            end else begin
                                w_next_state = SEND_NAK;
                            end
                        end
                        RX_IN: begin
                            if (tx_ready) begin
                                w_next_state = TX_SEND_DATA;
                                w_clr_error  = 1'b1;
                            end else begin
                                w_next_state = SEND_NAK;
                            end
                        end
                        RX_ERR:  w_set_error = 1'b1;
                        default: ;
                    endcase
                end
            end
            RX_WAIT_DATA: begin
                // A packet in the same cycle as the timeout takes precedence
                if (rx_packet_valid) begin
                    if (rx_packet == RX_DATA) begin
                        w_next_state = RX_RECEIVING;
                    end else begin
                        w_next_state = IDLE;
                        w_set_error  = 1'b1;
                        w_clear_req  = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_next_state = IDLE;
                    w_set_error  = 1'b1;
                    w_clear_req  = 1'b1;
                end
            end
            RX_RECEIVING: begin
                if (rx_done) begin
                    if (rx_crc_ok) begin
                        w_next_state = SEND_ACK;
                        w_set_rdr    = 1'b1;
                    end else begin
                        // Stay silent so the host retries the transfer
                        w_next_state = IDLE;
                        w_set_error  = 1'b1;
                        w_clear_req  = 1'b1;
                    end
                end
            end
            SEND_ACK, SEND_NAK: begin
                if (tx_done) begin
                    w_next_state = IDLE;
                end
            end
            TX_SEND_DATA: begin
                if (tx_done) begin
                    w_next_state = TX_WAIT_ACK;
                end
            end
            TX_WAIT_ACK: begin
                if (rx_packet_valid) begin
                    // Only an ACK releases the payload; anything else keeps it
                    w_next_state = IDLE;
                    if (rx_packet == RX_ACK) begin
                        w_clear_req = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_next_state = IDLE;
                    w_set_error  = 1'b1;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // TX command starts only on the cycle a sending state is entered
    assign w_tx_start_next = is_tx_state(w_next_state) && (w_next_state != r_state);

    // Registered pulses and sticky flags
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_tx_start <= 1'b0;
            r_clear    <= 1'b0;
            r_error    <= 1'b0;
            r_rdr      <= 1'b0;
        end else begin
            r_tx_start <= w_tx_start_next;
            r_clear    <= w_clear_req;
            if (w_set_error) begin
                r_error <= 1'b1;
            end else if (w_clr_error) begin
                r_error <= 1'b0;
            end
            if (w_set_rdr) begin
                r_rdr <= 1'b1;
            end else if ((r_state == IDLE) && w_occ_zero) begin
                r_rdr <= 1'b0;
            end
        end
    end

    // Buffer ownership, activity and TX packet type decoded from the state
    always_comb begin
        w_tx_pid           = TX_NONE;
        d_mode             = 1'b0;
        rx_transfer_active = 1'b0;
        tx_transfer_active = 1'b0;
        case (r_state)
            RX_WAIT_DATA, RX_RECEIVING: begin
                d_mode             = 1'b1;
                rx_transfer_active = 1'b1;
            end
            SEND_ACK: begin
                d_mode   = 1'b1;
                w_tx_pid = TX_ACK;
            end
            SEND_NAK: begin
                w_tx_pid = TX_NAK;
            end
            TX_SEND_DATA: begin
                d_mode             = 1'b1;
                tx_transfer_active = 1'b1;
                w_tx_pid           = TX_DATA;
            end
            TX_WAIT_ACK: begin
                d_mode             = 1'b1;
                tx_transfer_active = 1'b1;
            end
            default: ;
        endcase
    end

    assign tx_packet     = w_tx_pid;
    assign tx_start      = r_tx_start;
    assign clear_buffer  = r_clear;
    assign error         = r_error;
    assign rx_data_ready = r_rdr;

endmodule
`default_nettype wire

// File: tb/tb_usb_protocol_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_protocol_controller
// Description : Scoreboard bench for usb_protocol_controller. Expected TX
//               commands are queued with each stimulus and popped on tx_start.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_protocol_controller;
    import usb_pkg::*;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       rx_packet_valid;
    logic [2:0] rx_packet;
    logic       rx_done;
    logic       rx_crc_ok;
    logic       tx_done;
    logic       tx_ready;
    logic [6:0] buffer_occupancy;
    logic       tx_start;
    logic [1:0] tx_packet;
    logic       d_mode;
    logic       clear_buffer;
    logic       rx_data_ready;
    logic       rx_transfer_active;
    logic       tx_transfer_active;
    logic       error;

    int      total = 0;
    int      bad   = 0;
    int      n_tx_start = 0;
    int      n_clear    = 0;
    tx_pid_t exp_q[$];

    usb_protocol_controller #(
        .TIMEOUT_CYCLES (640),
        .ADDR_W         (7)
    ) dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .rx_packet_valid    (rx_packet_valid),
        .rx_packet          (rx_packet),
        .rx_done            (rx_done),
        .rx_crc_ok          (rx_crc_ok),
        .tx_done            (tx_done),
        .tx_ready           (tx_ready),
        .buffer_occupancy   (buffer_occupancy),
        .tx_start           (tx_start),
        .tx_packet          (tx_packet),
        .d_mode             (d_mode),
        .clear_buffer       (clear_buffer),
        .rx_data_ready      (rx_data_ready),
        .rx_transfer_active (rx_transfer_active),
        .tx_transfer_active (tx_transfer_active),
        .error              (error)
    );

    always #5 clk = ~clk;

    // Pulse counters for tx_start and clear_buffer
    always @(posedge clk) begin
        if (tx_start === 1'b1)     n_tx_start++;
        if (clear_buffer === 1'b1) n_clear++;
    end

    // Stimulus helpers: called at a negedge, return at the following negedge
    task automatic send_pid(input rx_pid_t pid);
        rx_packet       = pid;
        rx_packet_valid = 1'b1;
        @(negedge clk);
        rx_packet_valid = 1'b0;
        rx_packet       = 3'd0;
    endtask

    task automatic pulse_rx_done();
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic pulse_tx_done();
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic wait_tx_start(output bit found);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (tx_start === 1'b1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        total++;
        if ({tx_start, tx_packet, d_mode, clear_buffer, rx_data_ready,
             rx_transfer_active, tx_transfer_active, error} !== 9'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 000000000",
                     {tx_start, tx_packet, d_mode, clear_buffer, rx_data_ready,
                      rx_transfer_active, tx_transfer_active, error});
        end
    endtask

    task automatic test_out_ack();
        bit      found;
        tx_pid_t exp;
        buffer_occupancy = 7'd0;
        rx_crc_ok        = 1'b1;
        exp_q.push_back(TX_ACK);
        send_pid(RX_OUT);
        total++;
        if (d_mode !== 1'b1 || rx_transfer_active !== 1'b1) begin
            bad++;
            $display("FAIL out_accept: d_mode=%b rx_active=%b want 1 1", d_mode, rx_transfer_active);
        end
        send_pid(RX_DATA);
        buffer_occupancy = 7'd8;
        pulse_rx_done();
        wait_tx_start(found);
        exp = exp_q.pop_front();
        total++;
        if (!found || tx_packet !== exp) begin
            bad++;
            $display("FAIL out_ack_pkt: found=%0d pkt=%0d want found=1 pkt=%0d", found, tx_packet, exp);
        end
        total++;
        if (rx_data_ready !== 1'b1 || d_mode !== 1'b1) begin
            bad++;
            $display("FAIL out_ack_rdy: rdy=%b d_mode=%b want 1 1", rx_data_ready, d_mode);
        end
        @(negedge clk);
        total++;
        if (tx_start !== 1'b0) begin
            bad++;
            $display("FAIL out_ack_single: tx_start=%b want 0", tx_start);
        end
        pulse_tx_done();
        total++;
        if (d_mode !== 1'b0 || rx_data_ready !== 1'b1) begin
            bad++;
            $display("FAIL out_ack_done: d_mode=%b rdy=%b want 0 1", d_mode, rx_data_ready);
        end
        buffer_occupancy = 7'd0;
        @(negedge clk);
        total++;
        if (rx_data_ready !== 1'b0) begin
            bad++;
            $display("FAIL out_rdy_clear: rdy=%b want 0", rx_data_ready);
        end
    endtask

    task automatic test_out_nak();
        bit      found;
        bit      saw_usb;
        tx_pid_t exp;
        buffer_occupancy = 7'd12;
        exp_q.push_back(TX_NAK);
        send_pid(RX_OUT);
        saw_usb = d_mode;
        wait_tx_start(found);
        exp = exp_q.pop_front();
        total++;
        if (!found || tx_packet !== exp) begin
            bad++;
            $display("FAIL out_nak_pkt: found=%0d pkt=%0d want found=1 pkt=%0d", found, tx_packet, exp);
        end
        saw_usb |= d_mode;
        pulse_tx_done();
        saw_usb |= d_mode;
        total++;
        if (dut.r_state !== IDLE || saw_usb !== 1'b0) begin
            bad++;
            $display("FAIL out_nak_idle: state=%0d saw_d_mode=%b want 0 0", dut.r_state, saw_usb);
        end
    endtask

    task automatic test_in_ack();
        bit      found;
        tx_pid_t exp;
        buffer_occupancy = 7'd16;
        tx_ready         = 1'b1;
        exp_q.push_back(TX_DATA);
        send_pid(RX_IN);
        wait_tx_start(found);
        exp = exp_q.pop_front();
        total++;
        if (!found || tx_packet !== exp || tx_transfer_active !== 1'b1 || d_mode !== 1'b1) begin
            bad++;
            $display("FAIL in_data_pkt: found=%0d pkt=%0d tx_act=%b d_mode=%b want 1 %0d 1 1",
                     found, tx_packet, tx_transfer_active, d_mode, exp);
        end
        pulse_tx_done();
        total++;
        if (tx_transfer_active !== 1'b1 || clear_buffer !== 1'b0) begin
            bad++;
            $display("FAIL in_wait_ack: tx_act=%b clear=%b want 1 0", tx_transfer_active, clear_buffer);
        end
        send_pid(RX_ACK);
        total++;
        if (clear_buffer !== 1'b1 || tx_transfer_active !== 1'b0 || d_mode !== 1'b0) begin
            bad++;
            $display("FAIL in_ack_clear: clear=%b tx_act=%b d_mode=%b want 1 0 0",
                     clear_buffer, tx_transfer_active, d_mode);
        end
        @(negedge clk);
        total++;
        if (clear_buffer !== 1'b0) begin
            bad++;
            $display("FAIL in_ack_clear_width: clear=%b want 0", clear_buffer);
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_err_pid();
        send_pid(RX_ERR);
        total++;
        if (error !== 1'b1 || dut.r_state !== IDLE || d_mode !== 1'b0) begin
            bad++;
            $display("FAIL err_pid: error=%b state=%0d d_mode=%b want 1 0 0", error, dut.r_state, d_mode);
        end
    endtask

    task automatic test_in_timeout();
        bit      found;
        tx_pid_t exp;
        int      cyc;
        int      c0;
        tx_ready = 1'b1;
        exp_q.push_back(TX_DATA);
        send_pid(RX_IN);
        total++;
        if (error !== 1'b0) begin
            bad++;
            $display("FAIL in_clears_error: error=%b want 0", error);
        end
        wait_tx_start(found);
        exp = exp_q.pop_front();
        total++;
        if (!found || tx_packet !== exp) begin
            bad++;
            $display("FAIL to_data_pkt: found=%0d pkt=%0d want found=1 pkt=%0d", found, tx_packet, exp);
        end
        c0 = n_clear;
        pulse_tx_done();
        cyc = 0;
        while (tx_transfer_active === 1'b1 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        total++;
        if (cyc != 640 || error !== 1'b1) begin
            bad++;
            $display("FAIL tx_timeout: cycles=%0d error=%b want 640 1", cyc, error);
        end
        repeat (2) @(negedge clk);
        total++;
        if (n_clear != c0) begin
            bad++;
            $display("FAIL tx_timeout_noclear: clears=%0d want %0d", n_clear, c0);
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_crc_bad();
        bit      found;
        tx_pid_t exp;
        int      s0;
        buffer_occupancy = 7'd0;
        send_pid(RX_OUT);
        total++;
        if (error !== 1'b0) begin
            bad++;
            $display("FAIL out_clears_error: error=%b want 0", error);
        end
        send_pid(RX_DATA);
        rx_crc_ok = 1'b0;
        s0 = n_tx_start;
        pulse_rx_done();
        rx_crc_ok = 1'b1;
        total++;
        if (clear_buffer !== 1'b1 || error !== 1'b1 || d_mode !== 1'b0) begin
            bad++;
            $display("FAIL crc_bad: clear=%b error=%b d_mode=%b want 1 1 0", clear_buffer, error, d_mode);
        end
        repeat (3) @(negedge clk);
        total++;
        if (n_tx_start != s0) begin
            bad++;
            $display("FAIL crc_bad_no_tx: tx_starts=%0d want %0d", n_tx_start, s0);
        end
        tx_ready = 1'b1;
        exp_q.push_back(TX_DATA);
        send_pid(RX_IN);
        wait_tx_start(found);
        exp = exp_q.pop_front();
        total++;
        if (error !== 1'b0 || !found || tx_packet !== exp) begin
            bad++;
            $display("FAIL crc_then_in: error=%b found=%0d pkt=%0d want 0 1 %0d", error, found, tx_packet, exp);
        end
        pulse_tx_done();
        send_pid(RX_NAK);
        total++;
        if (clear_buffer !== 1'b0 || tx_transfer_active !== 1'b0) begin
            bad++;
            $display("FAIL in_nak_retain: clear=%b tx_act=%b want 0 0", clear_buffer, tx_transfer_active);
        end
        tx_ready = 1'b0;
    endtask

    task automatic test_rx_wrong_pid();
        buffer_occupancy = 7'd0;
        send_pid(RX_OUT);
        send_pid(RX_IN);
        total++;
        if (dut.r_state !== IDLE || error !== 1'b1 || clear_buffer !== 1'b1) begin
            bad++;
            $display("FAIL rx_wrong_pid: state=%0d error=%b clear=%b want 0 1 1", dut.r_state, error, clear_buffer);
        end
    endtask

    task automatic test_reset_mid();
        bit      found;
        tx_pid_t exp;
        int      c0;
        buffer_occupancy = 7'd0;
        send_pid(RX_OUT);
        send_pid(RX_DATA);
        c0 = n_clear;
        #2 n_rst = 1'b0;
        #1;
        total++;
        if ({tx_start, tx_packet, d_mode, clear_buffer, rx_data_ready,
             rx_transfer_active, tx_transfer_active, error} !== 9'd0) begin
            bad++;
            $display("FAIL reset_mid: got %b want 000000000",
                     {tx_start, tx_packet, d_mode, clear_buffer, rx_data_ready,
                      rx_transfer_active, tx_transfer_active, error});
        end
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        exp_q.push_back(TX_ACK);
        send_pid(RX_OUT);
        send_pid(RX_DATA);
        buffer_occupancy = 7'd4;
        pulse_rx_done();
        wait_tx_start(found);
        exp = exp_q.pop_front();
        total++;
        if (!found || tx_packet !== exp || n_clear != c0) begin
            bad++;
            $display("FAIL reset_recover: found=%0d pkt=%0d clears=%0d want 1 %0d %0d",
                     found, tx_packet, n_clear, exp, c0);
        end
        pulse_tx_done();
        total++;
        if (d_mode !== 1'b0 || rx_data_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_recover_done: d_mode=%b rdy=%b want 0 1", d_mode, rx_data_ready);
        end
    endtask

    initial begin
        n_rst            = 1'b0;
        rx_packet_valid  = 1'b0;
        rx_packet        = 3'd0;
        rx_done          = 1'b0;
        rx_crc_ok        = 1'b0;
        tx_done          = 1'b0;
        tx_ready         = 1'b0;
        buffer_occupancy = 7'd0;
        repeat (2) @(negedge clk);
        test_reset();
        n_rst = 1'b1;
        @(negedge clk);
        test_out_ack();
        test_out_nak();
        test_in_ack();
        test_err_pid();
        test_in_timeout();
        test_crc_bad();
        test_rx_wrong_pid();
        test_reset_mid();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: pending=%0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
